// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter with a valid/ready byte input.
// Sends one start bit (0), DATA_BITS data bits LSB first, and one stop bit (1).
// Every bit lasts exactly CLKS_PER_BIT clk cycles. The serial line is a flop,
// so tx follows the state register one cycle later. The frame therefore begins
// on the edge after the accepting edge.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        baud_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;
    logic                 tx_d;
    logic                 baud_last;

    // The current bit period ends on the edge after this cycle.
    assign baud_last = (baud_q == BAUD_LAST);

    // Select the line level for the current state. It is registered below.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FSM: handshake, baud timing, and the shift register. An asynchronous
    // reset abandons any frame in flight and forces the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            tx_q <= tx_d;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shift_q   <= tx_data;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == BIT_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // tx_ready depends only on the state, never on tx_valid.
    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx using three parameterisations:
//   idx 0: CLKS_PER_BIT=4,  DATA_BITS=8
//   idx 1: CLKS_PER_BIT=2,  DATA_BITS=5
//   idx 2: CLKS_PER_BIT=16, DATA_BITS=5
// The expected line waveform comes from the frame definition. The frame is an
// idle sample, then {0, data LSB first, 1}, with each bit repeated
// CLKS_PER_BIT times.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] data0;
    logic [4:0] data1;
    logic [4:0] data2;
    logic       valid0, valid1, valid2;
    logic       ready0, ready1, ready2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut0 (
        .clk(clk), .reset(reset), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .tx(tx0), .busy(busy0));
    uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut1 (
        .clk(clk), .reset(reset), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .tx(tx1), .busy(busy1));
    uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(5)) dut2 (
        .clk(clk), .reset(reset), .tx_data(data2), .tx_valid(valid2),
        .tx_ready(ready2), .tx(tx2), .busy(busy2));

    int n_cmp = 0;
    int n_bad = 0;

    bit cap_tx[$];
    bit cap_busy[$];
    bit cap_rdy[$];
    bit exp_tx[$];
    bit exp_busy[$];

    function automatic int cpb_of(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 2 : 16;
    endfunction

    function automatic int db_of(input int idx);
        return (idx == 0) ? 8 : 5;
    endfunction

    task automatic drive(input int idx, input logic v, input logic [7:0] d);
        case (idx)
            0: begin valid0 = v; data0 = d; end
            1: begin valid1 = v; data1 = d[4:0]; end
            default: begin valid2 = v; data2 = d[4:0]; end
        endcase
    endtask

    // Record n samples on successive falling edges. After the first sample,
    // apply a new tx_data and either drop or keep tx_valid.
    task automatic capture(input int idx, input int n, input bit drop, input logic [7:0] nd);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            case (idx)
                0: begin cap_tx.push_back(tx0); cap_busy.push_back(busy0); cap_rdy.push_back(ready0); end
                1: begin cap_tx.push_back(tx1); cap_busy.push_back(busy1); cap_rdy.push_back(ready1); end
                default: begin cap_tx.push_back(tx2); cap_busy.push_back(busy2); cap_rdy.push_back(ready2); end
            endcase
            if (k == 0) drive(idx, !drop, nd);
        end
    endtask

    // Present byte b on a falling edge and record the whole frame. Sample 0
    // is taken just after the accepting edge.
    task automatic send(input int idx, input logic [7:0] b, input logic [7:0] nd,
                        input bit drop, input int n);
        @(negedge clk);
        drive(idx, 1'b1, b);
        capture(idx, n, drop, nd);
        $display("frame: dut%0d byte %h (%0d samples)", idx, b, n);
    endtask

    // Reference frame: one idle-high sample, then every frame bit repeated
    // cpb times. busy stays high until the final sample.
    task automatic add_expected(input int idx, input logic [7:0] b);
        int  cpb;
        int  db;
        bit  bits[$];
        int  total;
        int  s;
        cpb = cpb_of(idx);
        db  = db_of(idx);
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) bits.push_back(b[i]);
        bits.push_back(1'b1);
        total = bits.size() * cpb;
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b1);
        s = 0;
        foreach (bits[i]) begin
            for (int r = 0; r < cpb; r++) begin
                s++;
                exp_tx.push_back(bits[i]);
                exp_busy.push_back(s != total);
            end
        end
    endtask

    task automatic clear_all();
        cap_tx.delete(); cap_busy.delete(); cap_rdy.delete();
        exp_tx.delete(); exp_busy.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b1, 8'hFF); drive(1, 1'b1, 8'hFF); drive(2, 1'b1, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx0, tx1, tx2, ready0, ready1, ready2, busy0, busy1, busy2} !== 9'b111_111_000) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d: tx/rdy/busy got %b%b%b/%b%b%b/%b%b%b want 111/111/000",
                         k, tx0, tx1, tx2, ready0, ready1, ready2, busy0, busy1, busy2);
            end
        end
        drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00); drive(2, 1'b0, 8'h00);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx0, tx1, tx2, ready0, ready1, ready2, busy0, busy1, busy2} !== 9'b111_111_000) begin
                n_bad++;
                $display("FAIL reset_idle cyc %0d: tx/rdy/busy got %b%b%b/%b%b%b/%b%b%b want 111/111/000",
                         k, tx0, tx1, tx2, ready0, ready1, ready2, busy0, busy1, busy2);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_a5();
        int nbusy;
        clear_all();
        send(0, 8'hA5, 8'hA5, 1'b1, 41);
        add_expected(0, 8'hA5);
        nbusy = 0;
        for (int k = 0; k < cap_tx.size(); k++) begin
            n_cmp++;
            if (cap_tx[k] !== exp_tx[k] || cap_busy[k] !== exp_busy[k] || cap_rdy[k] !== !exp_busy[k]) begin
                n_bad++;
                $display("FAIL single_a5 sample %0d: tx/busy/rdy got %b/%b/%b want %b/%b/%b",
                         k, cap_tx[k], cap_busy[k], cap_rdy[k], exp_tx[k], exp_busy[k], !exp_busy[k]);
            end
            if (cap_busy[k]) nbusy++;
        end
        n_cmp++;
        if (nbusy !== 40) begin
            n_bad++;
            $display("FAIL single_a5 busy_len: got %0d want 40", nbusy);
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        // Keep tx_valid high with 0xFF staged; the second frame is accepted
        // on the first idle edge.
        send(0, 8'h00, 8'hFF, 1'b0, 41);
        capture(0, 41, 1'b1, 8'hFF);
        add_expected(0, 8'h00);
        add_expected(0, 8'hFF);
        for (int k = 0; k < cap_tx.size(); k++) begin
            n_cmp++;
            if (cap_tx[k] !== exp_tx[k] || cap_busy[k] !== exp_busy[k] || cap_rdy[k] !== !exp_busy[k]) begin
                n_bad++;
                $display("FAIL back_to_back sample %0d: tx/busy/rdy got %b/%b/%b want %b/%b/%b",
                         k, cap_tx[k], cap_busy[k], cap_rdy[k], exp_tx[k], exp_busy[k], !exp_busy[k]);
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
            n_bad++;
            $display("FAIL back_to_back no_third: busy/tx got %b/%b want 0/1", busy0, tx0);
        end
    endtask

    task automatic test_data_stability();
        clear_all();
        send(0, 8'h3C, 8'hC3, 1'b1, 41);
        add_expected(0, 8'h3C);
        for (int k = 0; k < cap_tx.size(); k++) begin
            n_cmp++;
            if (cap_tx[k] !== exp_tx[k] || cap_busy[k] !== exp_busy[k]) begin
                n_bad++;
                $display("FAIL data_stable sample %0d: tx/busy got %b/%b want %b/%b",
                         k, cap_tx[k], cap_busy[k], exp_tx[k], exp_busy[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_all();
        // Samples 0..17 cover up to the first cycle of data bit 3.
        send(0, 8'h55, 8'h55, 1'b1, 18);
        add_expected(0, 8'h55);
        for (int k = 0; k < cap_tx.size(); k++) begin
            n_cmp++;
            if (cap_tx[k] !== exp_tx[k] || cap_busy[k] !== exp_busy[k]) begin
                n_bad++;
                $display("FAIL mid_reset prefix %0d: tx/busy got %b/%b want %b/%b",
                         k, cap_tx[k], cap_busy[k], exp_tx[k], exp_busy[k]);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (tx0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset async: tx/rdy/busy got %b/%b/%b want 1/1/0", tx0, ready0, busy0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tx0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset quiet %0d: tx/rdy/busy got %b/%b/%b want 1/1/0", k, tx0, ready0, busy0);
            end
        end
        clear_all();
        send(0, 8'h81, 8'h81, 1'b1, 41);
        add_expected(0, 8'h81);
        for (int k = 0; k < cap_tx.size(); k++) begin
            n_cmp++;
            if (cap_tx[k] !== exp_tx[k] || cap_busy[k] !== exp_busy[k]) begin
                n_bad++;
                $display("FAIL mid_reset resend %0d: tx/busy got %b/%b want %b/%b",
                         k, cap_tx[k], cap_busy[k], exp_tx[k], exp_busy[k]);
            end
        end
    endtask

    task automatic test_param_sweep();
        int nbusy;
        for (int idx = 1; idx <= 2; idx++) begin
            clear_all();
            send(idx, 8'h15, 8'h15, 1'b1, 7 * cpb_of(idx) + 1);
            add_expected(idx, 8'h15);
            nbusy = 0;
            for (int k = 0; k < cap_tx.size(); k++) begin
                n_cmp++;
                if (cap_tx[k] !== exp_tx[k] || cap_busy[k] !== exp_busy[k] || cap_rdy[k] !== !exp_busy[k]) begin
                    n_bad++;
                    $display("FAIL sweep dut%0d sample %0d: tx/busy/rdy got %b/%b/%b want %b/%b/%b",
                             idx, k, cap_tx[k], cap_busy[k], cap_rdy[k], exp_tx[k], exp_busy[k], !exp_busy[k]);
                end
                if (cap_busy[k]) nbusy++;
            end
            n_cmp++;
            if (nbusy !== ((idx == 1) ? 14 : 112)) begin
                n_bad++;
                $display("FAIL sweep dut%0d busy_len: got %0d want %0d", idx, nbusy, (idx == 1) ? 14 : 112);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int idx = 0; idx <= 2; idx++) begin
            for (int t = 0; t < 4; t++) begin
                clear_all();
                b = 8'($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(idx, b, 8'($urandom), 1'b1, (db_of(idx) + 2) * cpb_of(idx) + 1);
                add_expected(idx, b);
                for (int k = 0; k < cap_tx.size(); k++) begin
                    n_cmp++;
                    if (cap_tx[k] !== exp_tx[k] || cap_busy[k] !== exp_busy[k] || cap_rdy[k] !== !exp_busy[k]) begin
                        n_bad++;
                        $display("FAIL random dut%0d byte %h sample %0d: tx/busy/rdy got %b/%b/%b want %b/%b/%b",
                                 idx, b, k, cap_tx[k], cap_busy[k], cap_rdy[k], exp_tx[k], exp_busy[k], !exp_busy[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        data0 = '0; data1 = '0; data2 = '0;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_data_stability();
        test_reset_mid_frame();
        test_param_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
